// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard, forwarding and flush controller for the 5-stage RV32I pipeline.
//   Decodes the ID instruction and tracks a shadow EX/MA/WB pipeline of
//   destination/writeback info. It produces the PC/IF-ID stall, the EX bubble,
//   the branch flush and registered ALU-operand forward selects. It also keeps
//   saturating stall/flush counters.
//
// Parameters
//   FWD_EN    : 1 = forward from MA/WB, 0 = stall on every RAW hazard
//   RF_BYPASS : 1 = write-through regfile (WB producer needs no stall)
//   CNT_W     : performance counter width
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   inst_Id         : instruction in ID
//   inst_Id_valid   : ID holds a real instruction
//   br_taken        : branch/jump taken in EX this cycle
//   stall_pc        : hold PC
//   stall_Id        : hold IF/ID
//   flush_Id        : load NOP into IF/ID
//   bubble_Ex       : load NOP into ID/EX
//   fwdA_sel/B_sel  : EX operand source (00 regfile, 01 MA, 10 WB)
//   stall_cnt       : stalled cycles (saturating)
//   flush_cnt       : taken-branch flushes (saturating)
module hazard_fwd_unit #(
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          RF_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_Id,
  input  logic             inst_Id_valid,
  input  logic             br_taken,
  output logic             stall_pc,
  output logic             stall_Id,
  output logic             flush_Id,
  output logic             bubble_Ex,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_MA = 2'b01;
  localparam logic [1:0] SEL_WB = 2'b10;

  slot_t            r_ex, r_ma, r_wb;
  logic [1:0]       r_fwdA, r_fwdB;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic [4:0] w_rs1, w_rs2, w_rd;
  logic       w_use1, w_use2, w_wr_op, w_ld, w_wr;
  logic       w_hzA_ex, w_hzB_ex, w_hzA_ma, w_hzB_ma, w_hzA_wb, w_hzB_wb;
  logic       w_raw, w_stall, w_issue;
  logic [1:0] w_selA, w_selB;
  logic       w_unused_bits;

  function automatic logic f_hz(input slot_t s, input logic used, input logic [4:0] rs);
    return s.valid && used && (rs != 5'd0) && s.wr && (s.rd == rs);
  endfunction

  assign w_rs1 = inst_Id[19:15];
  assign w_rs2 = inst_Id[24:20];
  assign w_rd  = inst_Id[11:7];

  assign w_unused_bits = ^{inst_Id[31:25], inst_Id[14:12], r_wb.ld};

  // A bubble in ID reads nothing, so it can never raise a hazard.
  always_comb begin
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_wr_op = 1'b0;
    w_ld    = 1'b0;
    if (inst_Id_valid) begin
      case (inst_Id[6:0])
        OPC_LUI, OPC_AUIPC, OPC_JAL: w_wr_op = 1'b1;
        OPC_JALR:   begin w_use1 = 1'b1; w_wr_op = 1'b1; end
        OPC_BRANCH: begin w_use1 = 1'b1; w_use2  = 1'b1; end
        OPC_LOAD:   begin w_use1 = 1'b1; w_wr_op = 1'b1; w_ld = 1'b1; end
        OPC_STORE:  begin w_use1 = 1'b1; w_use2  = 1'b1; end
        OPC_OPIMM:  begin w_use1 = 1'b1; w_wr_op = 1'b1; end
        OPC_OP:     begin w_use1 = 1'b1; w_use2  = 1'b1; w_wr_op = 1'b1; end
        default: ;
      endcase
    end
  end

  assign w_wr = w_wr_op && (w_rd != 5'd0);

  assign w_hzA_ex = f_hz(r_ex, w_use1, w_rs1);
  assign w_hzB_ex = f_hz(r_ex, w_use2, w_rs2);
  assign w_hzA_ma = f_hz(r_ma, w_use1, w_rs1);
  assign w_hzB_ma = f_hz(r_ma, w_use2, w_rs2);
  assign w_hzA_wb = f_hz(r_wb, w_use1, w_rs1);
  assign w_hzB_wb = f_hz(r_wb, w_use2, w_rs2);

  always_comb begin
    w_raw = 1'b0;
    if (FWD_EN) begin
      w_raw = (w_hzA_ex || w_hzB_ex) && r_ex.ld;
    end else begin
      w_raw = w_hzA_ex || w_hzB_ex || w_hzA_ma || w_hzB_ma ||
              (!RF_BYPASS && (w_hzA_wb || w_hzB_wb));
    end
  end

  // Branch beats stall: the held ID instruction is on the wrong path.
  assign w_stall   = w_raw && !reset;
  assign stall_pc  = w_stall && !br_taken;
  assign stall_Id  = w_stall && !br_taken;
  assign flush_Id  = br_taken && !reset;
  assign bubble_Ex = (w_stall || br_taken) && !reset;
  assign w_issue   = inst_Id_valid && !bubble_Ex;

  // The Ex slot moves to Ma and Ma to Wb at the same edge this instruction
  // enters EX, so the newer (Ex) producer maps to the MA source.
  assign w_selA = w_hzA_ex ? SEL_MA : (w_hzA_ma ? SEL_WB : SEL_RF);
  assign w_selB = w_hzB_ex ? SEL_MA : (w_hzB_ma ? SEL_WB : SEL_RF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_ma        <= '0;
      r_wb        <= '0;
      r_fwdA      <= SEL_RF;
      r_fwdB      <= SEL_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb <= r_ma;
      r_ma <= r_ex;
      if (w_issue) begin
        r_ex <= '{valid: 1'b1, rd: w_rd, wr: w_wr, ld: w_ld};
      end else begin
        r_ex <= '0;
      end
      if (w_issue && FWD_EN) begin
        r_fwdA <= w_selA;
        r_fwdB <= w_selB;
      end else begin
        r_fwdA <= SEL_RF;
        r_fwdB <= SEL_RF;
      end
      if (stall_pc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (br_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign fwdA_sel  = r_fwdA;
  assign fwdB_sel  = r_fwdB;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit. Three instances share one stimulus stream:
//   k=0: FWD_EN=1 RF_BYPASS=1 CNT_W=4
//   k=1: FWD_EN=0 RF_BYPASS=0 CNT_W=16
//   k=2: FWD_EN=0 RF_BYPASS=1 CNT_W=16
// The reference model tracks, per register, the cycle its latest producer
// left ID and whether it was a load; hazard distance is a cycle difference.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        reset, inst_vld, br;
  logic [31:0] inst;

  logic       spc[3], sid[3], fl[3], bub[3];
  logic [1:0] fa[3], fb[3];
  logic [3:0]  sc0, fc0;
  logic [15:0] sc1, fc1, sc2, fc2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(4)) u_f (
    .clk(clk), .reset(reset), .inst_Id(inst), .inst_Id_valid(inst_vld), .br_taken(br),
    .stall_pc(spc[0]), .stall_Id(sid[0]), .flush_Id(fl[0]), .bubble_Ex(bub[0]),
    .fwdA_sel(fa[0]), .fwdB_sel(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_fwd_unit #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(16)) u_s0 (
    .clk(clk), .reset(reset), .inst_Id(inst), .inst_Id_valid(inst_vld), .br_taken(br),
    .stall_pc(spc[1]), .stall_Id(sid[1]), .flush_Id(fl[1]), .bubble_Ex(bub[1]),
    .fwdA_sel(fa[1]), .fwdB_sel(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_fwd_unit #(.FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(16)) u_s1 (
    .clk(clk), .reset(reset), .inst_Id(inst), .inst_Id_valid(inst_vld), .br_taken(br),
    .stall_pc(spc[2]), .stall_Id(sid[2]), .flush_Id(fl[2]), .bubble_Ex(bub[2]),
    .fwdA_sel(fa[2]), .fwdB_sel(fb[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // ---------------- reference model ----------------
  int cfg_fwd[3] = '{1, 0, 0};
  int cfg_byp[3] = '{1, 0, 1};
  int cfg_max[3] = '{15, 65535, 65535};

  int last_wr[3][32];
  bit last_ld[3][32];
  int exp_fa[3], exp_fb[3], exp_sc[3], exp_fc[3];
  int cyc = 0;
  bit init = 1'b0;

  function automatic int get_sc(int k);
    case (k)
      0: return int'(sc0);
      1: return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  function automatic int get_fc(int k);
    case (k)
      0: return int'(fc0);
      1: return int'(fc1);
      default: return int'(fc2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] i, input bit v,
                                 output bit u1, output bit u2, output bit wr, output bit ld);
    u1 = 0; u2 = 0; wr = 0; ld = 0;
    if (v) begin
      case (i[6:0])
        7'h37, 7'h17, 7'h6f: wr = 1;
        7'h67: begin u1 = 1; wr = 1; end
        7'h63: begin u1 = 1; u2 = 1; end
        7'h03: begin u1 = 1; wr = 1; ld = 1; end
        7'h23: begin u1 = 1; u2 = 1; end
        7'h13: begin u1 = 1; wr = 1; end
        7'h33: begin u1 = 1; u2 = 1; wr = 1; end
        default: ;
      endcase
    end
    if (i[11:7] == 5'd0) wr = 0;
  endfunction

  // One clock cycle: drive, check every instance against the model, advance model.
  task automatic step(input logic [31:0] i, input bit v, input bit b, input bit r);
    bit u1, u2, wr, ld, raw, e_st, e_spc, e_fl, e_bub, issue;
    int d1, d2, s1, s2;
    int rs1, rs2, rd;
    @(negedge clk);
    inst = i; inst_vld = v; br = b; reset = r;
    #1;
    decode(i, v, u1, u2, wr, ld);
    rs1 = int'(i[19:15]); rs2 = int'(i[24:20]); rd = int'(i[11:7]);
    for (int k = 0; k < 3; k++) begin
      if (init) begin
        chk($sformatf("fwdA[%0d]", k), int'(fa[k]), exp_fa[k]);
        chk($sformatf("fwdB[%0d]", k), int'(fb[k]), exp_fb[k]);
        chk($sformatf("stall_cnt[%0d]", k), get_sc(k), exp_sc[k]);
        chk($sformatf("flush_cnt[%0d]", k), get_fc(k), exp_fc[k]);
      end
      d1 = (u1 && rs1 != 0) ? cyc - last_wr[k][rs1] : 1000;
      d2 = (u2 && rs2 != 0) ? cyc - last_wr[k][rs2] : 1000;
      if (cfg_fwd[k] != 0)
        raw = (d1 == 1 && last_ld[k][rs1]) || (d2 == 1 && last_ld[k][rs2]);
      else
        raw = (d1 <= 2) || (d2 <= 2) || (cfg_byp[k] == 0 && (d1 == 3 || d2 == 3));
      e_st  = raw && !r;
      e_spc = e_st && !b;
      e_fl  = b && !r;
      e_bub = (e_st || b) && !r;
      chk($sformatf("stall_pc[%0d]", k), int'(spc[k]), int'(e_spc));
      chk($sformatf("stall_Id[%0d]", k), int'(sid[k]), int'(e_spc));
      chk($sformatf("flush_Id[%0d]", k), int'(fl[k]), int'(e_fl));
      chk($sformatf("bubble_Ex[%0d]", k), int'(bub[k]), int'(e_bub));
      issue = v && !e_bub && !r;
      s1 = (d1 == 1) ? 1 : (d1 == 2) ? 2 : 0;
      s2 = (d2 == 1) ? 1 : (d2 == 2) ? 2 : 0;
      exp_fa[k] = (issue && cfg_fwd[k] != 0) ? s1 : 0;
      exp_fb[k] = (issue && cfg_fwd[k] != 0) ? s2 : 0;
      if (r) begin
        for (int j = 0; j < 32; j++) begin
          last_wr[k][j] = -100;
          last_ld[k][j] = 0;
        end
        exp_sc[k] = 0;
        exp_fc[k] = 0;
      end else begin
        if (issue && wr) begin
          last_wr[k][rd] = cyc + 0;
          last_ld[k][rd] = ld;
        end
        if (e_spc && exp_sc[k] < cfg_max[k]) exp_sc[k]++;
        if (b && exp_fc[k] < cfg_max[k]) exp_fc[k]++;
      end
    end
    if (r) init = 1'b1;
    cyc++;
  endtask

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input int rd, input int a, input int b);
    return {f7, 5'(b), 5'(a), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] f_addi(input int rd, input int a, input int imm);
    return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] f_lw(input int rd, input int a);
    return {12'd0, 5'(a), 3'b010, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] f_add(input int rd, input int a, input int b);
    return f_r(7'h00, 3'b000, rd, a, b);
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- directed table (checked on instance k=0) ----------------
  typedef struct {
    logic [31:0] inst;
    bit          v, b;
    bit          e_spc, e_fl, e_bub;
    logic [1:0]  e_fa, e_fb;
    int          e_sc, e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] i, input bit b, input bit spc_e, input bit fl_e,
                              input bit bub_e, input int fa_e, input int fb_e,
                              input int sc_e, input int fc_e);
    vec_t t;
    t.inst = i; t.v = 1'b1; t.b = b;
    t.e_spc = spc_e; t.e_fl = fl_e; t.e_bub = bub_e;
    t.e_fa = 2'(fa_e); t.e_fb = 2'(fb_e);
    t.e_sc = sc_e; t.e_fc = fc_e;
    return t;
  endfunction

  int cnt1, cnt2;
  logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f, 7'h00};

  initial begin
    // ALU chain
    tbl.push_back(mk(f_add(5, 1, 2),              0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(f_r(7'h20, 3'b000, 6, 5, 3), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(f_r(7'h00, 3'b110, 7, 5, 6), 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 0, 0));
    // x0 immunity
    tbl.push_back(mk(f_addi(0, 0, 1),             0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(f_add(3, 0, 0),              0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 0, 0));
    // load-use
    tbl.push_back(mk(f_lw(5, 1),                  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(f_add(6, 5, 5),              0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(f_add(6, 5, 5),              0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 1, 0));
    // branch during load-use stall
    tbl.push_back(mk(f_lw(8, 1),                  0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(f_add(9, 8, 0),              1, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(NOP,                         0, 0, 0, 0, 0, 0, 1, 1));

    reset = 1'b1; inst = NOP; inst_vld = 1'b0; br = 1'b0;
    step(NOP, 0, 0, 1);
    step(NOP, 0, 0, 1);

    foreach (tbl[n]) begin
      step(tbl[n].inst, tbl[n].v, tbl[n].b, 0);
      chk($sformatf("tbl%0d stall_pc", n),  int'(spc[0]), int'(tbl[n].e_spc));
      chk($sformatf("tbl%0d flush_Id", n),  int'(fl[0]),  int'(tbl[n].e_fl));
      chk($sformatf("tbl%0d bubble_Ex", n), int'(bub[0]), int'(tbl[n].e_bub));
      chk($sformatf("tbl%0d fwdA", n),      int'(fa[0]),  int'(tbl[n].e_fa));
      chk($sformatf("tbl%0d fwdB", n),      int'(fb[0]),  int'(tbl[n].e_fb));
      chk($sformatf("tbl%0d stall_cnt", n), int'(sc0),    tbl[n].e_sc);
      chk($sformatf("tbl%0d flush_cnt", n), int'(fc0),    tbl[n].e_fc);
    end

    // Stall-only mode: producer immediately ahead of its consumer.
    step(NOP, 0, 0, 1);
    step(f_add(5, 1, 2), 1, 0, 0);
    cnt1 = 0; cnt2 = 0;
    for (int n = 0; n < 6; n++) begin
      step(f_add(6, 5, 0), 1, 0, 0);
      if (spc[1]) cnt1++;
      if (spc[2]) cnt2++;
      chk("s0 fwdA stays 00", int'(fa[1]), 0);
      chk("s1 fwdA stays 00", int'(fa[2]), 0);
    end
    chk("stall-only nobypass stall cycles", cnt1, 3);
    chk("stall-only bypass stall cycles", cnt2, 2);

    // Saturation: 20 load-use stalls on the CNT_W=4 instance.
    step(NOP, 0, 0, 1);
    for (int n = 0; n < 20; n++) begin
      step(f_lw(5, 1), 1, 0, 0);
      step(f_add(6, 5, 5), 1, 0, 0);
      step(f_add(6, 5, 5), 1, 0, 0);
    end
    step(NOP, 0, 0, 0);
    chk("stall_cnt saturated", int'(sc0), 15);

    // Reset asserted in the load-use stall cycle.
    step(f_lw(5, 1), 1, 0, 0);
    step(f_add(6, 5, 5), 1, 0, 1);
    chk("reset forces stall_pc 0", int'(spc[0]), 0);
    chk("reset forces bubble 0", int'(bub[0]), 0);
    step(f_add(6, 5, 5), 1, 0, 0);
    chk("post-reset stall", int'(spc[0]), 0);
    chk("post-reset stall_cnt", int'(sc0), 0);
    chk("post-reset flush_cnt", int'(fc0), 0);
    chk("post-reset fwdA", int'(fa[0]), 0);
    chk("post-reset fwdB", int'(fb[0]), 0);

    // Randomized traffic on a small register pool to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      ri = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
      step(ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
